// File: rtl/pio_imem_arbiter.sv
// Arbiter for the single-port PIO instruction RAM: host program-load writes (priority,
// burst-limited) vs. round-robin SM fetches. Define PIO_IMEM_STATS_EN for conflict_cnt.
module pio_imem_arbiter #(
    parameter int NUM_SM         = 4,
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 16,
    parameter int HOST_BURST_MAX = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     host_wr_req,
    input  logic [ADDR_W-1:0]        host_waddr,
    input  logic [DATA_W-1:0]        host_wdata,
    output logic                     host_wr_ack,
    input  logic [NUM_SM-1:0]        sm_req,
    input  logic [NUM_SM*ADDR_W-1:0] sm_addr,
    output logic [NUM_SM-1:0]        sm_gnt,
    output logic [NUM_SM-1:0]        sm_rvalid,
    output logic [DATA_W-1:0]        sm_rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_wr,
    output logic                     mem_rd,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [15:0]              conflict_cnt
);
    localparam int PTR_W = $clog2(NUM_SM);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic              rd_owner_valid_q, rd_owner_valid_d;
    logic [PTR_W-1:0]  rd_owner_q, rd_owner_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic              sm_any;
    logic              host_gnt;
    logic              sm_gnt_en;
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  scan_idx;
    logic [ADDR_W-1:0] sm_addr_arr [NUM_SM];

    for (genvar g = 0; g < NUM_SM; g++) begin : g_addr
        assign sm_addr_arr[g] = sm_addr[g*ADDR_W +: ADDR_W];
    end

    assign sm_any = |sm_req;

    // Nothing is granted while reset is asserted, so every strobe reads 0 in reset.
    assign host_gnt = reset && host_wr_req &&
                      (!sm_any || (burst_cnt_q < 4'(HOST_BURST_MAX)));

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + i) % NUM_SM);
            if (!win_found && sm_req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign sm_gnt_en = reset && !host_gnt && win_found;

    always_comb begin
        sm_gnt           = '0;
        mem_wr           = 1'b0;
        mem_rd           = 1'b0;
        host_wr_ack      = 1'b0;
        mem_wdata        = '0;
        mem_addr_d       = mem_addr_q;
        rr_ptr_d         = rr_ptr_q;
        rd_owner_valid_d = sm_gnt_en;
        rd_owner_d       = rd_owner_q;
        if (host_gnt) begin
            mem_wr      = 1'b1;
            host_wr_ack = 1'b1;
            mem_wdata   = host_wdata;
            mem_addr_d  = host_waddr;
        end else if (sm_gnt_en) begin
            sm_gnt[win_idx] = 1'b1;
            mem_rd          = 1'b1;
            mem_addr_d      = sm_addr_arr[win_idx];
            rd_owner_d      = win_idx;
            rr_ptr_d        = (int'(win_idx) == NUM_SM - 1) ? '0 : win_idx + 1'b1;
        end
        // Host streak only counts while some SM is waiting; it saturates at the limit.
        if (host_gnt && sm_any) begin
            burst_cnt_d = (burst_cnt_q >= 4'(HOST_BURST_MAX)) ? burst_cnt_q
                                                              : burst_cnt_q + 4'd1;
        end else begin
            burst_cnt_d = '0;
        end
    end

    assign mem_addr = mem_addr_d;

    always_comb begin
        sm_rvalid = '0;
        sm_rdata  = '0;
        if (rd_owner_valid_q) begin
            sm_rvalid[rd_owner_q] = 1'b1;
            sm_rdata              = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q         <= '0;
            burst_cnt_q      <= '0;
            rd_owner_valid_q <= 1'b0;
            rd_owner_q       <= '0;
            mem_addr_q       <= '0;
        end else begin
            rr_ptr_q         <= rr_ptr_d;
            burst_cnt_q      <= burst_cnt_d;
            rd_owner_valid_q <= rd_owner_valid_d;
            rd_owner_q       <= rd_owner_d;
            mem_addr_q       <= mem_addr_d;
        end
    end

`ifdef PIO_IMEM_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic        denied;

    assign denied = (host_wr_req && !host_gnt) || ((sm_req & ~sm_gnt) != '0);

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (denied && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pio_imem_arbiter.sv
// Self-checking bench for pio_imem_arbiter: directed scenarios followed by random
// request traffic, all compared against a rule-level model of the arbiter.
module tb_pio_imem_arbiter;
    localparam int N    = 4;
    localparam int AW   = 5;
    localparam int DW   = 16;
    localparam int BMAX = 4;
`ifdef PIO_IMEM_STATS_EN
    localparam int EXP_CONF4 = 4;
`else
    localparam int EXP_CONF4 = 0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            host_wr_req;
    logic [AW-1:0]   host_waddr;
    logic [DW-1:0]   host_wdata;
    logic            host_wr_ack;
    logic [N-1:0]    sm_req;
    logic [N*AW-1:0] sm_addr;
    logic [N-1:0]    sm_gnt;
    logic [N-1:0]    sm_rvalid;
    logic [DW-1:0]   sm_rdata;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_wr;
    logic            mem_rd;
    logic [DW-1:0]   mem_rdata;
    logic [15:0]     conflict_cnt;

    pio_imem_arbiter #(.NUM_SM(N), .ADDR_W(AW), .DATA_W(DW), .HOST_BURST_MAX(BMAX)) dut (
        .clk(clk), .reset(reset),
        .host_wr_req(host_wr_req), .host_waddr(host_waddr), .host_wdata(host_wdata),
        .host_wr_ack(host_wr_ack),
        .sm_req(sm_req), .sm_addr(sm_addr), .sm_gnt(sm_gnt),
        .sm_rvalid(sm_rvalid), .sm_rdata(sm_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Instruction RAM with one-cycle registered read.
    logic [DW-1:0] ram [32];
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            m_rr;
    int            m_streak;
    int            m_ret_owner;
    int            m_conf;
    logic [DW-1:0] m_ret_data;
    logic [AW-1:0] m_last_addr;
    logic [DW-1:0] mmem [32];
    bit            e_host;
    int            e_w;

    // Observed values of the last cycle
    logic          obs_ack;
    logic [AW-1:0] obs_addr;
    logic [N-1:0]  obs_gnt;
    logic [N-1:0]  obs_rvalid;
    logic [DW-1:0] obs_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr        = 0;
        m_streak    = 0;
        m_ret_owner = -1;
        m_conf      = 0;
        m_last_addr = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"},    32'(sm_gnt),       32'd0);
        check({tag, "_rvalid"}, 32'(sm_rvalid),    32'd0);
        check({tag, "_ack"},    32'(host_wr_ack),  32'd0);
        check({tag, "_wr"},     32'(mem_wr),       32'd0);
        check({tag, "_rd"},     32'(mem_rd),       32'd0);
        check({tag, "_addr"},   32'(mem_addr),     32'd0);
        check({tag, "_wdata"},  32'(mem_wdata),    32'd0);
        check({tag, "_rdata"},  32'(sm_rdata),     32'd0);
        check({tag, "_conf"},   32'(conflict_cnt), 32'd0);
    endtask

    // One clock cycle: predict at mid-cycle, compare, then advance the model at the edge.
    task automatic cycle();
        logic [N-1:0]  egnt;
        logic [AW-1:0] eaddr;
        logic [N-1:0]  ervalid;
        bit            denied;
        @(negedge clk);
        e_host = host_wr_req && (sm_req == '0 || m_streak < BMAX);
        e_w    = -1;
        if (!e_host) begin
            for (int k = 0; k < N; k++) begin
                if (e_w < 0 && sm_req[(m_rr + k) % N]) e_w = (m_rr + k) % N;
            end
        end
        egnt    = (e_w >= 0) ? N'(1 << e_w) : '0;
        ervalid = (m_ret_owner >= 0) ? N'(1 << m_ret_owner) : '0;
        if (e_host)       eaddr = host_waddr;
        else if (e_w >= 0) eaddr = sm_addr[e_w*AW +: AW];
        else              eaddr = m_last_addr;

        check("ack",      32'(host_wr_ack),  32'(e_host));
        check("mem_wr",   32'(mem_wr),       32'(e_host));
        check("mem_rd",   32'(mem_rd),       32'(e_w >= 0));
        check("sm_gnt",   32'(sm_gnt),       32'(egnt));
        check("mem_addr", 32'(mem_addr),     32'(eaddr));
        if (e_host) check("mem_wdata", 32'(mem_wdata), 32'(host_wdata));
        check("rvalid",   32'(sm_rvalid),    32'(ervalid));
        if (m_ret_owner >= 0) check("rdata", 32'(sm_rdata), 32'(m_ret_data));
        check("conflict", 32'(conflict_cnt), 32'(m_conf));

        obs_ack    = host_wr_ack;
        obs_addr   = mem_addr;
        obs_gnt    = sm_gnt;
        obs_rvalid = sm_rvalid;
        obs_rdata  = sm_rdata;

        denied = (host_wr_req && !e_host) || ((sm_req & ~egnt) != '0);
        @(posedge clk);
        if (e_host) mmem[host_waddr] = host_wdata;
        m_last_addr = eaddr;
        m_ret_owner = e_w;
        if (e_w >= 0) begin
            m_ret_data = mmem[sm_addr[e_w*AW +: AW]];
            m_rr       = (e_w + 1) % N;
        end
        if (e_host && sm_req != '0) m_streak = (m_streak < BMAX) ? m_streak + 1 : BMAX;
        else                        m_streak = 0;
`ifdef PIO_IMEM_STATS_EN
        if (denied && m_conf < 16'hFFFF) m_conf++;
`endif
        #1;
    endtask

    initial begin
        int nack;
        logic [N-1:0] rr_seq [5];
        logic [6:0]   st_ack;
        logic [6:0]   st_gnt;

        host_wr_req = 1'b0;
        host_waddr  = '0;
        host_wdata  = '0;
        sm_req      = '0;
        sm_addr     = '0;
        reset       = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;

        // Preload every word through the host port.
        nack = 0;
        for (int a = 0; a < 32; a++) begin
            host_wr_req = 1'b1;
            host_waddr  = AW'(a);
            host_wdata  = DW'($urandom);
            cycle();
            if (obs_ack) nack++;
        end
        host_wr_req = 1'b0;
        check("preload_acks", 32'(nack), 32'd32);

        // Host write then SM0 fetch of the same word.
        host_wr_req = 1'b1;
        host_waddr  = 5'd3;
        host_wdata  = 16'h1234;
        cycle();
        check("host_ack", 32'(obs_ack), 32'd1);
        check("host_addr", 32'(obs_addr), 32'd3);
        host_wr_req  = 1'b0;
        sm_req       = 4'b0001;
        sm_addr[4:0] = 5'd3;
        cycle();
        check("fetch_gnt", 32'(obs_gnt), 32'b0001);
        sm_req = '0;
        cycle();
        check("fetch_rvalid", 32'(obs_rvalid), 32'b0001);
        check("fetch_rdata", 32'(obs_rdata), 32'h1234);

        // Grant SM2, then reset before its data returns.
        sm_req         = 4'b0100;
        sm_addr[14:10] = 5'd7;
        cycle();
        check("midrd_gnt", 32'(obs_gnt), 32'b0100);
        sm_req      = 4'b1111;
        host_wr_req = 1'b1;
        reset       = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        reset       = 1'b1;
        host_wr_req = 1'b0;

        // Round-robin from reset with all SMs requesting.
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int c = 0; c < 5; c++) begin
            sm_addr = N*AW'($urandom);
            cycle();
            check("rr_gnt", 32'(obs_gnt), 32'(rr_seq[c]));
            check("rr_rvalid", 32'(obs_rvalid), (c == 0) ? 32'd0 : 32'(rr_seq[c-1]));
        end
        sm_req = '0;
        cycle();
        check("rr_last_rvalid", 32'(obs_rvalid), 32'b0001);

        // Conflict counter from a fresh reset.
        reset = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        sm_req = 4'b0011;
        for (int c = 0; c < 4; c++) cycle();
        sm_req = '0;
        check("conflict4", 32'(conflict_cnt), 32'(EXP_CONF4));

        // Host burst limit with SM1 waiting.
        st_ack      = 7'b1101111;
        st_gnt      = 7'b0010000;
        host_wr_req = 1'b1;
        host_waddr  = AW'($urandom);
        host_wdata  = DW'($urandom);
        sm_req      = 4'b0010;
        for (int c = 0; c < 7; c++) begin
            cycle();
            check("burst_ack", 32'(obs_ack), 32'(st_ack[c]));
            check("burst_gnt1", 32'(obs_gnt[1]), 32'(st_gnt[c]));
            if (obs_gnt[1]) sm_req = '0;
            if (obs_ack) begin
                host_waddr = AW'($urandom);
                host_wdata = DW'($urandom);
            end
        end

        // Ten host writes with no SM traffic.
        nack = 0;
        for (int c = 0; c < 10; c++) begin
            host_waddr = AW'($urandom);
            host_wdata = DW'($urandom);
            cycle();
            if (obs_ack) nack++;
        end
        host_wr_req = 1'b0;
        check("host10_acks", 32'(nack), 32'd10);
        cycle();

        // Random traffic obeying hold-until-granted.
        for (int n = 0; n < 400; n++) begin
            if (!host_wr_req || e_host) begin
                host_wr_req = ($urandom_range(0, 2) == 0);
                host_waddr  = AW'($urandom);
                host_wdata  = DW'($urandom);
            end
            for (int i = 0; i < N; i++) begin
                if (!sm_req[i] || e_w == i) begin
                    sm_req[i]           = ($urandom_range(0, 1) == 1);
                    sm_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
